// File: rtl/rv32v_uop_sequencer.sv
// rv32v_uop_sequencer
//   Splits one accepted vector instruction into per-register micro-ops.
//   One uop is issued per destination register of the (clamped) register
//   group. Each uop carries register numbers offset by the uop index, the
//   index of its first element, and its active element count.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake (in_ready = sequencer idle)
//   vd, vs1, vs2      base register numbers
//   vsew, vlmul       element width / register-group multiplier encodings
//   vl, vill          active vector length, vtype-illegal flag
//   uop_valid/ready   uop handshake toward the execution pipe
//   uop_vd/vs1/vs2    per-uop register numbers
//   uop_eidx          index of the first element in this uop
//   uop_ecnt          active elements in this uop
//   uop_last          final uop of the instruction
//   busy              instruction in progress
//   illegal           one-cycle pulse when an illegal instruction is rejected
module rv32v_uop_sequencer #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 vd,
  input  logic [4:0]                 vs1,
  input  logic [4:0]                 vs2,
  input  logic [2:0]                 vsew,
  input  logic [2:0]                 vlmul,
  input  logic [31:0]                vl,
  input  logic                       vill,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [4:0]                 uop_vd,
  output logic [4:0]                 uop_vs1,
  output logic [4:0]                 uop_vs2,
  output logic [31:0]                uop_eidx,
  output logic [$clog2(VLEN/8):0]    uop_ecnt,
  output logic                       uop_last,
  output logic                       busy,
  output logic                       illegal
);

  localparam int CW = $clog2(VLEN/8) + 1;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      uop_vd_q, uop_vd_d;
  logic [4:0]      uop_vs1_q, uop_vs1_d;
  logic [4:0]      uop_vs2_q, uop_vs2_d;
  logic [31:0]     eidx_q, eidx_d;
  logic [CW-1:0]   ecnt_q, ecnt_d;
  logic            last_q, last_d;
  logic [31:0]     rem_q, rem_d;    // elements still to issue after the current uop
  logic [CW-1:0]   epr_q, epr_d;    // elements per register of the captured instruction
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            in_illegal;
  logic [31:0]     sew_bits;
  logic [31:0]     in_epr;
  logic [31:0]     in_vlmax;
  logic [31:0]     in_vle;
  logic [31:0]     in_ecnt;
  logic [31:0]     epr_w;
  logic [31:0]     next_ecnt;

  // Decode of the presented instruction; only consumed on accept.
  always_comb begin
    accept     = in_valid && (state_q == S_IDLE);
    sew_bits   = 32'd8 << vsew[1:0];
    in_illegal = vill || vsew[2] || (vlmul == 3'b100) || (sew_bits > 32'(ELEN));
    in_epr     = 32'(VLEN) >> (32'd3 + 32'(vsew[1:0]));
    // Fractional multipliers occupy a single register.
    in_vlmax   = in_epr << (vlmul[2] ? 2'd0 : vlmul[1:0]);
    in_vle     = (vl < in_vlmax) ? vl : in_vlmax;
    in_ecnt    = (in_vle < in_epr) ? in_vle : in_epr;
    epr_w      = 32'(epr_q);
    next_ecnt  = (rem_q < epr_w) ? rem_q : epr_w;
  end

  always_comb begin
    state_d   = state_q;
    uop_vd_d  = uop_vd_q;
    uop_vs1_d = uop_vs1_q;
    uop_vs2_d = uop_vs2_q;
    eidx_d    = eidx_q;
    ecnt_d    = ecnt_q;
    last_d    = last_q;
    rem_d     = rem_q;
    epr_d     = epr_q;
    illegal_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_illegal) begin
            illegal_d = 1'b1;
          end else if (in_vle != 32'd0) begin
            state_d   = S_ISSUE;
            uop_vd_d  = vd;
            uop_vs1_d = vs1;
            uop_vs2_d = vs2;
            eidx_d    = '0;
            ecnt_d    = CW'(in_ecnt);
            last_d    = (in_vle <= in_epr);
            rem_d     = in_vle - in_ecnt;
            epr_d     = CW'(in_epr);
          end
        end
      end
      S_ISSUE: begin
        if (uop_ready) begin
          if (last_q) begin
            // Fields return to zero so they read 0 while no uop is valid.
            state_d   = S_IDLE;
            uop_vd_d  = '0;
            uop_vs1_d = '0;
            uop_vs2_d = '0;
            eidx_d    = '0;
            ecnt_d    = '0;
            last_d    = 1'b0;
            rem_d     = '0;
            epr_d     = '0;
          end else begin
            uop_vd_d  = uop_vd_q + 5'd1;
            uop_vs1_d = uop_vs1_q + 5'd1;
            uop_vs2_d = uop_vs2_q + 5'd1;
            eidx_d    = eidx_q + epr_w;
            ecnt_d    = CW'(next_ecnt);
            last_d    = (rem_q <= epr_w);
            rem_d     = rem_q - next_ecnt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      uop_vd_q  <= '0;
      uop_vs1_q <= '0;
      uop_vs2_q <= '0;
      eidx_q    <= '0;
      ecnt_q    <= '0;
      last_q    <= 1'b0;
      rem_q     <= '0;
      epr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      uop_vd_q  <= uop_vd_d;
      uop_vs1_q <= uop_vs1_d;
      uop_vs2_q <= uop_vs2_d;
      eidx_q    <= eidx_d;
      ecnt_q    <= ecnt_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      epr_q     <= epr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_ISSUE);
    uop_valid = (state_q == S_ISSUE);
    uop_vd    = uop_vd_q;
    uop_vs1   = uop_vs1_q;
    uop_vs2   = uop_vs2_q;
    uop_eidx  = eidx_q;
    uop_ecnt  = ecnt_q;
    uop_last  = last_q;
    illegal   = illegal_q;
  end

endmodule

// File: doc/rv32v_uop_sequencer.md
RV32V_UOP_SEQUENCER -- requirements
Module: rv32v_uop_sequencer

Interface
REQ-001 Parameter VLEN, default 128, vector register width in bits (power of two, >=64).
REQ-002 Parameter ELEN, default 32, maximum supported element width in bits (8, 16, 32 or 64).
REQ-003 Ports: CLK  in  1  clock; RST  in  1  reset (one clock; synchronous, active-high).
REQ-004 in_valid  in  1  vector instruction presented; in_ready  out  1  sequencer can accept.
REQ-005 vd, vs1, vs2  in  5 each  base register numbers.
REQ-006 vsew  in  3  000=8, 001=16, 010=32, 011=64, others reserved; vlmul  in  3  000=1, 001=2, 010=4, 011=8, 101/110/111 fractional (one register), 100 reserved.
REQ-007 vl  in  32  active vector length; vill  in  1  vtype illegal flag.
REQ-008 uop_valid  out  1; uop_ready  in  1  downstream accepts (low = stall).
REQ-009 uop_vd, uop_vs1, uop_vs2  out  5 each  per-uop register numbers.
REQ-010 uop_eidx  out  32  index of first element in uop; uop_ecnt  out  $clog2(VLEN/8)+1  active elements in uop; uop_last  out  1  final uop of instruction.
REQ-011 busy  out  1  instruction in progress; illegal  out  1  one-cycle reject pulse.

Function
REQ-012 FSM states IDLE and ISSUE only; in_ready SHALL equal (state==IDLE).
REQ-013 Accept = in_valid && in_ready; all inputs captured in registers on accept; inputs ignored otherwise.
REQ-014 Illegal if vill=1, vsew reserved, vlmul=100, or (8<<vsew)>ELEN; on illegal accept: illegal=1 next cycle for exactly one cycle, state stays IDLE, no uop.
REQ-015 EPR (elements per register) = VLEN/(8<<vsew); LMULR = 1,2,4,8 per vlmul, 1 for fractional.
REQ-016 Effective length VLE = min(vl, EPR*LMULR); NUOP = ceil(VLE/EPR).
REQ-017 Legal accept with VLE=0: no uop, no illegal pulse, state stays IDLE.
REQ-018 Legal accept with VLE>0: state ISSUE next cycle, busy=1, uop_valid=1 in cycle after accept (latency 1).
REQ-019 Uop k (k=0..NUOP-1): uop_vd=(vd+k) mod 32, uop_vs1=(vs1+k) mod 32, uop_vs2=(vs2+k) mod 32, uop_eidx=k*EPR, uop_ecnt=min(EPR, VLE-k*EPR), uop_last=(k==NUOP-1).
REQ-020 All uop_* outputs registered; SHALL be held stable while uop_valid && !uop_ready.
REQ-021 Handshake uop_valid && uop_ready advances k; next uop valid the following cycle, no bubble.
REQ-022 Handshake on uop_last: state IDLE next cycle, uop_valid=0, busy=0, in_ready=1; no same-cycle new accept.
REQ-023 busy=1 exactly while state==ISSUE.
REQ-024 uop_* fields SHALL read 0 when uop_valid=0.
REQ-025 uop_ready ignored when uop_valid=0; no combinational path from uop_ready to any output.

Reset
REQ-026 RST sampled high: next cycle state=IDLE, in_ready=1, uop_valid=0, busy=0, illegal=0, all uop_* fields=0.
REQ-027 RST mid-ISSUE aborts instruction; no remaining uops issued after reset.
REQ-028 RST has priority over a simultaneous accept or uop handshake.

Verification (VLEN=128, ELEN=32)
REQ-029 vsew=010, vlmul=001, vl=8, vd=4, vs1=12, vs2=8 -> two uops: (4,12,8,eidx 0,ecnt 4,last 0), then (5,13,9,eidx 4,ecnt 4,last 1).
REQ-030 Same but vl=6 -> ecnt 4 then 2; vl=20 -> clamped to 8, identical to REQ-029.
REQ-031 vsew=000, vlmul=010, vl=64, vd=31 -> four uops, uop_vd 31,0,1,2, eidx 0,16,32,48, ecnt 16 each.
REQ-032 uop_ready held low 3 cycles during uop 0 of REQ-029 -> all uop_* outputs unchanged, then uop 1 cycle after ready rises.
REQ-033 vill=1, or vsew=011 (64>ELEN), or vlmul=100 -> single illegal pulse, no uop_valid, in_ready stays 1; vl=0 legal -> no uop, no pulse.
REQ-034 RST asserted after first uop handshake of REQ-031 -> next cycle uop_valid=0, busy=0, in_ready=1; no further uops.
